fpu_addsub_param: RTL and testbench

//  Parametrised multi-cycle floating-point adder/subtractor; successor to the fixed 32-bit adder FSM.

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/fpu_lzc.sv | 18 +
 rtl/fpu_addsub_param.sv | 210 +++++++++++++++++++++
 tb/tb_fpu_addsub_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types for the parametrised FP add/sub unit.
// Holds the one-hot status encoding, FSM states and the bias helper.
package fpu_pkg;

   typedef enum logic [3:0] {
      ST_EXACT     = 4'b0001,
      ST_INEXACT   = 4'b0010,
      ST_OVERFLOW  = 4'b0100,
      ST_UNDERFLOW = 4'b1000
   } status_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_PACK
   } state_t;

   function automatic int bias(input int exp_w);
      return (2 ** (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: combinational leading-zero counter of width W.
// Ports: din (W bits) in, count out (W when din is all zero).
module fpu_lzc #(
   parameter int W  = 29,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  din,
   output logic [CW-1:0] count
);

   // Scanning upward, the last set bit seen is the MSB.
   always_comb begin
      count = CW'(W);
      for (int i = 0; i < W; i++)
         if (din[i]) count = CW'(W - 1 - i);
   end

endmodule

// File: rtl/fpu_addsub_param.sv
// fpu_addsub_param: multi-cycle FP adder/subtractor, RNE, no denormals.
// Ports: clock100KHz, reset (async low), in_valid/in_ready, op_sub_in,
//   op_A_in/op_B_in (W), out_valid pulse, data_out (W), status_out (4).
// Macro FPU_SATURATE_EN: overflow gives max finite instead of all-ones exp.
module fpu_addsub_param
   import fpu_pkg::*;
#(
   parameter int EXP_W  = 6,
   parameter int MANT_W = 25
) (
   input  logic                    clock100KHz,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    op_sub_in,
   input  logic [EXP_W+MANT_W:0]   op_A_in,
   input  logic [EXP_W+MANT_W:0]   op_B_in,
   output logic                    out_valid,
   output logic [EXP_W+MANT_W:0]   data_out,
   output logic [3:0]              status_out
);

   localparam int W     = 1 + EXP_W + MANT_W;
   localparam int MW    = MANT_W + 4;
   localparam int SW    = MANT_W + 5;
   localparam int LZW   = $clog2(MW + 1);
   localparam int XW    = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
   localparam int SHMAX = MANT_W + 3;
   localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** EXP_W) - 1);

   state_t state, state_nxt;

   logic [W-1:0]          a_q, b_q;
   logic                  sub_q;
   logic                  sign_q, eff_sub_q;
   logic                  zero_q, flush_q, inexact_q;
   logic signed [XW-1:0]  exp_q;
   logic [MW-1:0]         ml_q, ms_q;
   logic [SW-1:0]         sum_q;
   logic [MW-2:0]         nm_q;
   logic [MANT_W-1:0]     frac_q;

   always_ff @(posedge clock100KHz or negedge reset)
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (in_valid) state_nxt = S_ALIGN;
         S_ALIGN: state_nxt = S_ADD;
         S_ADD:   state_nxt = S_NORM;
         S_NORM:  state_nxt = S_ROUND;
         S_ROUND: state_nxt = S_PACK;
         S_PACK:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign in_ready = (state == S_IDLE);

   // Align: larger magnitude goes to the "l" side, small side is
   // right-shifted with shifted-out bits folded into sticky.
   logic [EXP_W-1:0]  ea, eb, el, es, diff;
   logic [MANT_W-1:0] fa, fb, fl, fs;
   logic              sa, sb, sl, ss, swap;
   logic [MW-1:0]     ml, ms_full, ms;
   int                sh;

   always_comb begin
      ea      = a_q[W-2 -: EXP_W];
      eb      = b_q[W-2 -: EXP_W];
      fa      = (ea != '0) ? a_q[MANT_W-1:0] : '0;
      fb      = (eb != '0) ? b_q[MANT_W-1:0] : '0;
      sa      = a_q[W-1];
      sb      = b_q[W-1] ^ sub_q;
      swap    = {eb, fb} > {ea, fa};
      el      = swap ? eb : ea;
      es      = swap ? ea : eb;
      fl      = swap ? fb : fa;
      fs      = swap ? fa : fb;
      sl      = swap ? sb : sa;
      ss      = swap ? sa : sb;
      ml      = (el != '0) ? {1'b1, fl, 3'b000} : '0;
      ms_full = (es != '0) ? {1'b1, fs, 3'b000} : '0;
      diff    = el - es;
      sh      = (int'(diff) > SHMAX) ? SHMAX : int'(diff);
      ms      = ms_full >> sh;
      ms[0]   = ms[0] | (|(ms_full & ~({MW{1'b1}} << sh)));
   end

   logic [SW-1:0] sum;
   assign sum = eff_sub_q ? ({1'b0, ml_q} - {1'b0, ms_q})
                          : ({1'b0, ml_q} + {1'b0, ms_q});

   logic [LZW-1:0]       lz;
   logic signed [XW-1:0] exp_lz;

   fpu_lzc #(.W(MW)) u_lzc (
      .din   (sum_q[MW-1:0]),
      .count (lz)
   );

   assign exp_lz = exp_q - $signed(XW'(lz));

   logic              rnd_up;
   logic [MANT_W:0]   frac_rnd;
   assign rnd_up   = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
   assign frac_rnd = {1'b0, nm_q[MW-2:3]} + (MANT_W+1)'(rnd_up);

   logic         ovf;
   status_t      stat;
   logic [W-1:0] res;

   always_comb begin
      ovf = !zero_q && !flush_q && (exp_q >= EXP_MAX);
      res = {sign_q, exp_q[EXP_W-1:0], frac_q};
      if (ovf)
`ifdef FPU_SATURATE_EN
         res = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
`else
         res = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
`endif
      else if (zero_q || flush_q)
         res = {sign_q, {(W-1){1'b0}}};
      priority case (1'b1)
         ovf:       stat = ST_OVERFLOW;
         flush_q:   stat = ST_UNDERFLOW;
         inexact_q: stat = ST_INEXACT;
         default:   stat = ST_EXACT;
      endcase
   end

   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         a_q        <= '0;
         b_q        <= '0;
         sub_q      <= 1'b0;
         sign_q     <= 1'b0;
         eff_sub_q  <= 1'b0;
         zero_q     <= 1'b0;
         flush_q    <= 1'b0;
         inexact_q  <= 1'b0;
         exp_q      <= '0;
         ml_q       <= '0;
         ms_q       <= '0;
         sum_q      <= '0;
         nm_q       <= '0;
         frac_q     <= '0;
         out_valid  <= 1'b0;
         data_out   <= '0;
         status_out <= ST_EXACT;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            S_IDLE:
               if (in_valid) begin
                  a_q   <= op_A_in;
                  b_q   <= op_B_in;
                  sub_q <= op_sub_in;
               end
            S_ALIGN: begin
               sign_q    <= sl;
               eff_sub_q <= sl ^ ss;
               exp_q     <= XW'(el);
               ml_q      <= ml;
               ms_q      <= ms;
               zero_q    <= 1'b0;
               flush_q   <= 1'b0;
               inexact_q <= 1'b0;
            end
            S_ADD: begin
               sum_q <= sum;
               // Cancellation gives +0; like-signed zeros keep sign.
               if (sum == '0) begin
                  zero_q <= 1'b1;
                  sign_q <= sign_q & ~eff_sub_q;
               end
            end
            S_NORM:
               if (!zero_q) begin
                  if (sum_q[SW-1]) begin
                     nm_q  <= {sum_q[SW-2:2], |sum_q[1:0]};
                     exp_q <= exp_q + XW'(1);
                  end else begin
                     nm_q  <= sum_q[MW-2:0] << lz;
                     exp_q <= exp_lz;
                     if (exp_lz[XW-1] || exp_lz == '0) flush_q <= 1'b1;
                  end
               end
            S_ROUND: begin
               inexact_q <= !zero_q && !flush_q && (|nm_q[2:0]);
               if (frac_rnd[MANT_W]) begin
                  frac_q <= '0;
                  exp_q  <= exp_q + XW'(1);
               end else begin
                  frac_q <= frac_rnd[MANT_W-1:0];
               end
            end
            S_PACK: begin
               data_out   <= res;
               status_out <= stat;
               out_valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_addsub_param.sv
// tb_fpu_addsub_param: directed and random checks of fpu_addsub_param.
// Reference model works on exact wide integers, then rounds to nearest-even.
module tb_fpu_addsub_param;
   import fpu_pkg::*;

   localparam int EW = 6;
   localparam int MW = 25;
   localparam int WW = 32;
   localparam logic [WW-1:0] ONE = {1'b0, 6'(bias(EW)), 25'b0};

   logic          clock100KHz = 1'b0;
   logic          reset       = 1'b0;
   logic          in_valid    = 1'b0;
   logic          in_ready;
   logic          op_sub_in   = 1'b0;
   logic [WW-1:0] op_A_in     = '0;
   logic [WW-1:0] op_B_in     = '0;
   logic          out_valid;
   logic [WW-1:0] data_out;
   logic [3:0]    status_out;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock100KHz = ~clock100KHz;

   fpu_addsub_param #(.EXP_W(EW), .MANT_W(MW)) dut (
      .clock100KHz (clock100KHz),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op_sub_in   (op_sub_in),
      .op_A_in     (op_A_in),
      .op_B_in     (op_B_in),
      .out_valid   (out_valid),
      .data_out    (data_out),
      .status_out  (status_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic ref_model(input logic [31:0] a, input logic [31:0] b,
                            input logic s, output logic [31:0] r,
                            output logic [3:0] st);
      logic [127:0] ma, mb, mag, q, rem, half;
      int ea, eb, p, e, sh;
      logic sa, sb, sr, inx;
      ea = int'(a[30:25]);
      eb = int'(b[30:25]);
      ma = (ea != 0) ? (128'({1'b1, a[24:0]}) << (ea - 1)) : '0;
      mb = (eb != 0) ? (128'({1'b1, b[24:0]}) << (eb - 1)) : '0;
      sa = a[31];
      sb = b[31] ^ s;
      if (ma == 0 && mb == 0) begin
         r = {sa & sb, 31'b0}; st = 4'b0001; return;
      end
      if (sa == sb) begin mag = ma + mb; sr = sa; end
      else if (ma >= mb) begin mag = ma - mb; sr = sa; end
      else begin mag = mb - ma; sr = sb; end
      if (mag == 0) begin r = '0; st = 4'b0001; return; end
      p = 0;
      for (int i = 0; i < 128; i++) if (mag[i]) p = i;
      e = 1 + p - MW;
      if (e <= 0) begin r = {sr, 31'b0}; st = 4'b1000; return; end
      sh  = p - MW;
      q   = mag >> sh;
      rem = mag & ((128'd1 << sh) - 128'd1);
      inx = (rem != 0);
      if (sh > 0) begin
         half = 128'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 128'd1;
      end
      if (q[MW+1]) begin q = q >> 1; e++; end
      if (e >= 63) begin
`ifdef FPU_SATURATE_EN
         r = {sr, 6'h3E, 25'h1FFFFFF};
`else
         r = {sr, 6'h3F, 25'h0};
`endif
         st = 4'b0100;
      end else begin
         r  = {sr, 6'(e), q[24:0]};
         st = inx ? 4'b0010 : 4'b0001;
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] er,
                         input logic [3:0] es, input string tag);
      int lat;
      lat = 0;
      for (int c = 0; c < 20 && !in_ready; c++) @(negedge clock100KHz);
      @(negedge clock100KHz);
      in_valid = 1'b1; op_A_in = a; op_B_in = b; op_sub_in = s;
      @(posedge clock100KHz);
      #1;
      in_valid  = 1'b0;
      op_A_in   = $urandom;
      op_B_in   = $urandom;
      op_sub_in = 1'($urandom_range(0, 1));
      for (int c = 1; c <= 10; c++) begin
         @(posedge clock100KHz);
         #1;
         if (out_valid) begin lat = c; break; end
      end
      chk({tag, ".lat"}, 32'(lat), 32'd5);
      chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
      chk({tag, ".data"}, data_out, er);
      chk({tag, ".stat"}, 32'(status_out), 32'(es));
      @(posedge clock100KHz);
      #1;
      chk({tag, ".pulse"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] a, b, er, ovf_r;
      logic [3:0]  es;
      logic        s;
      int          c1, c2;

`ifdef FPU_SATURATE_EN
      ovf_r = 32'h7DFFFFFF;
`else
      ovf_r = 32'h7E000000;
`endif

      #12;
      chk("rst.data", data_out, 32'h0);
      chk("rst.stat", 32'(status_out), 32'h1);
      chk("rst.oval", 32'(out_valid), 32'h0);
      chk("rst.rdy", 32'(in_ready), 32'h1);
      @(negedge clock100KHz);
      reset = 1'b1;

      run_op(ONE, ONE, 1'b0, 32'h40000000, 4'b0001, "t1_add");
      run_op(ONE, ONE, 1'b1, 32'h00000000, 4'b0001, "t2_cancel");
      run_op(ONE, 32'h0A000000, 1'b0, 32'h3E000000, 4'b0010, "t3_tie_even");
      run_op(32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'b0010,
             "t3_tie_odd");
      run_op(ONE, 32'h0C000000, 1'b0, 32'h3E000001, 4'b0001, "t3_lsb");
      run_op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001,
             "negzero");
      run_op(32'h02000001, 32'h02000000, 1'b1, 32'h00000000, 4'b1000,
             "t5_flush");
      run_op(32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, ovf_r, 4'b0100, "t4_ovf");

      // Reset asserted while the op sits in NORM.
      @(negedge clock100KHz);
      in_valid = 1'b1; op_A_in = ONE; op_B_in = ONE; op_sub_in = 1'b0;
      @(posedge clock100KHz);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clock100KHz);
      #2 reset = 1'b0;
      #1;
      chk("rstN.data", data_out, 32'h0);
      chk("rstN.stat", 32'(status_out), 32'h1);
      chk("rstN.oval", 32'(out_valid), 32'h0);
      chk("rstN.rdy", 32'(in_ready), 32'h1);
      @(negedge clock100KHz);
      reset = 1'b1;
      run_op(ONE, 32'h0A000000, 1'b0, 32'h3E000000, 4'b0010, "post_rst");

      // in_valid held high: second op only taken once the first is done.
      @(negedge clock100KHz);
      in_valid = 1'b1; op_A_in = ONE; op_B_in = ONE; op_sub_in = 1'b0;
      @(posedge clock100KHz);
      #1 op_sub_in = 1'b1;
      c1 = 0;
      c2 = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clock100KHz);
         #1;
         if (c == 2) chk("b2b.busy", 32'(in_ready), 32'd0);
         if (out_valid && c1 == 0) begin
            c1 = c;
            chk("b2b.d1", data_out, 32'h40000000);
            chk("b2b.s1", 32'(status_out), 32'h1);
         end else if (out_valid && c2 == 0) begin
            c2 = c;
            chk("b2b.d2", data_out, 32'h00000000);
            chk("b2b.s2", 32'(status_out), 32'h1);
            in_valid = 1'b0;
            break;
         end
      end
      in_valid = 1'b0;
      chk("b2b.lat1", 32'(c1), 32'd5);
      chk("b2b.gap", 32'(c2 - c1), 32'd6);
      repeat (8) @(posedge clock100KHz);

      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         b = $urandom;
         s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: b[30:25] = a[30:25];
            1: b[30:25] = a[30:25] - 6'($urandom_range(0, 3));
            2: b[30:25] = 6'd0;
            3: begin b = a; b[1:0] = 2'($urandom); end
            default: ;
         endcase
         ref_model(a, b, s, er, es);
         run_op(a, b, s, er, es, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
